uart_gpio_loader: RTL and testbench
===================================

Name: uart_gpio_loader

Overview:
- Top-level peripheral wrapper for the anti-theft compartment SoC.
- Receives an 8N1 UART byte stream and assembles bytes into 32-bit instruction words, least-significant byte first.
- Writes the assembled words into an internal instruction memory and flags completion of loading.
- Also provides a 1-bit GPIO path, gated by load completion.

Parameters:
- CLK_HZ, 50000000, system clock frequency in Hz.
- BIT_RATE, 9600, UART baud rate; CYCLES_PER_BIT = CLK_HZ/BIT_RATE (integer division, 5208 at defaults).
- IMEM_DEPTH, 32, instruction memory depth in 32-bit words; power of two; AW = log2(IMEM_DEPTH).
- GPIO_IN_W, 1, input GPIO width.
- GPIO_OUT_W, 1, output GPIO width; must equal GPIO_IN_W.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- uart_rxd  in  1  UART receive line; idles high; asynchronous to clk.
- uart_rx_en  in  1  receive enable; when 0 the receiver stays in IDLE.
- uart_rx_break  out  1  one-cycle pulse on a detected BREAK frame.
- uart_rx_valid  out  1  one-cycle pulse when a good byte is received.
- uart_rx_data  out  8  last good byte received; held until the next good byte.
- input_gpio_pins  in  GPIO_IN_W  external inputs; asynchronous.
- output_gpio_pins  out  GPIO_OUT_W  external outputs.
- write_done  out  1  sticky flag: loading finished.
- imem_raddr  in  AW  instruction memory read address.
- imem_rdata  out  32  combinational read of mem[imem_raddr].

Behaviour:
- Reset values:
  - all outputs 0;
  - byte counter 0, write address 0, receiver in IDLE;
  - memory contents are not cleared.
- Input synchronisation: uart_rxd and input_gpio_pins each pass through a 2-flop synchroniser; the uart_rxd synchroniser resets to 1.
- Receiver FSM:
  - IDLE: if uart_rx_en=1 and the synchronised rxd is 0, go to START.
  - START: wait CYCLES_PER_BIT/2. If rxd is still 0, go to DATA; otherwise return to IDLE (glitch rejection).
  - DATA: sample 8 bits, one every CYCLES_PER_BIT, LSB first, into a shift register.
  - STOP: after CYCLES_PER_BIT, sample the stop bit.
    - stop=1: uart_rx_data <= shift register; uart_rx_valid pulses one cycle.
    - stop=0: framing error; no valid pulse, data unchanged.
    - Then return to IDLE.
  - If uart_rx_en drops during a frame, the frame is aborted and the FSM goes to IDLE with no pulse.
  - uart_rx_valid and uart_rx_break never both assert.
- Loader (acts only on uart_rx_valid pulses while write_done=0):
  - Byte k (k=0..3) goes to word[8k+7:8k]; the counter advances each pulse.
  - On the 4th byte the counter wraps to 0 and the assembled word is evaluated.
    - Word == 32'hFFFFFFFF: terminator; not stored; write_done <= 1.
    - Otherwise: mem[waddr] <= word; waddr <= waddr+1. If waddr was IMEM_DEPTH-1 (memory full), write_done <= 1.
  - Once write_done=1, further bytes are still reported on uart_rx_valid/uart_rx_data but do not change memory, counter or write_done. Only rst clears write_done.
- GPIO:
  - While write_done=0, output_gpio_pins = 0.
  - While write_done=1, output_gpio_pins is registered from the synchronised inputs: 3 clk cycles total latency from a pin change.
- Reset mid-frame: the receiver returns to IDLE and the partial word is discarded.

Optional Feature:
- Macro UART_BREAK_DETECT_EN.
- Defined: in STOP, if stop=0 and all 8 data bits are 0, uart_rx_break pulses one cycle and uart_rx_valid does not. The FSM then waits for the synchronised rxd to return to 1 before entering IDLE.
- Undefined: uart_rx_break is tied to 0, and such frames are treated as ordinary framing errors.

Test Plan:
- Reset held 200 cycles with rxd=1 -> all outputs 0, imem_rdata = whatever the memory holds; no valid pulse.
- uart_rx_en=1; send byte 0xA5 at 9600 baud -> exactly one uart_rx_valid pulse; uart_rx_data=8'hA5 and held afterwards.
- Send words 32'hFE010113 then 32'h00812E23, byte-serial LSB first:
  - 8 valid pulses, each uart_rx_data matching the byte just sent;
  - imem_raddr=0 -> 32'hFE010113; imem_raddr=1 -> 32'h00812E23; write_done=0.
- Send 32'hFFFFFFFF -> write_done=1 and mem[2] unchanged. A following 32'hFFFFFFFF and 32'h12345678 leave memory and write_done unchanged.
- After write_done=1, toggle input_gpio_pins 0/1 every 200 cycles -> output follows 3 cycles later. Before write_done, the output stays 0 under the same toggling.
- With UART_BREAK_DETECT_EN: hold rxd low for 12 bit times -> uart_rx_break pulses once and no valid pulse. With uart_rx_en=0, sending 0x3C -> no pulses.

Source files
------------

// File: rtl/uart_gpio_loader_if.sv
// Pin bundle of the UART instruction loader: receive line, received-byte report,
// GPIO pins, load status and the instruction memory read port.
interface uart_gpio_loader_if #(
   parameter int unsigned GPIO_IN_W  = 1,
   parameter int unsigned GPIO_OUT_W = 1,
   parameter int unsigned AW         = 5
);
   logic                  uart_rxd;
   logic                  uart_rx_en;
   logic                  uart_rx_break;
   logic                  uart_rx_valid;
   logic [7:0]            uart_rx_data;
   logic [GPIO_IN_W-1:0]  input_gpio_pins;
   logic [GPIO_OUT_W-1:0] output_gpio_pins;
   logic                  write_done;
   logic [AW-1:0]         imem_raddr;
   logic [31:0]           imem_rdata;

   // Environment side: drives the line, enable, pins and read address.
   modport master (
      output uart_rxd, uart_rx_en, input_gpio_pins, imem_raddr,
      input  uart_rx_break, uart_rx_valid, uart_rx_data, output_gpio_pins,
             write_done, imem_rdata
   );

   // Loader side.
   modport slave (
      input  uart_rxd, uart_rx_en, input_gpio_pins, imem_raddr,
      output uart_rx_break, uart_rx_valid, uart_rx_data, output_gpio_pins,
             write_done, imem_rdata
   );
endinterface

// File: rtl/uart_gpio_loader.sv
// 8N1 UART receiver that packs bytes LSB-first into 32-bit words, loads them into an
// instruction memory and then opens a synchronised GPIO path. BREAK detection is built
// only when UART_BREAK_DETECT_EN is defined.
module uart_gpio_loader #(
   parameter int unsigned CLK_HZ     = 50000000,
   parameter int unsigned BIT_RATE   = 9600,
   parameter int unsigned IMEM_DEPTH = 32,
   parameter int unsigned GPIO_IN_W  = 1,
   parameter int unsigned GPIO_OUT_W = 1
) (
   input logic                clk,
   input logic                rst,
   uart_gpio_loader_if.slave  bus
);

   localparam int unsigned CYCLES_PER_BIT = CLK_HZ / BIT_RATE;
   localparam int unsigned AW             = $clog2(IMEM_DEPTH);
   localparam int unsigned CNT_W          = (CYCLES_PER_BIT > 2) ? $clog2(CYCLES_PER_BIT) : 1;
   localparam int unsigned BIT_LAST       = CYCLES_PER_BIT - 1;
   localparam int unsigned HALF_LAST      = (CYCLES_PER_BIT >= 2) ? (CYCLES_PER_BIT / 2) - 1 : 0;
   localparam int unsigned LAST_ADDR      = IMEM_DEPTH - 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_BRK_WAIT
   } rx_state_e;

   rx_state_e state_q, state_d;

   logic                  rxd_meta_q, rxd_sync_q;
   logic [GPIO_IN_W-1:0]  gpio_meta_q, gpio_sync_q;
   logic [GPIO_OUT_W-1:0] gpio_out_q, gpio_out_d;

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       bit_idx_q, bit_idx_d;
   logic [7:0]       shift_q, shift_d;
   logic [7:0]       rx_data_q, rx_data_d;
   logic             valid_q, valid_d;
   logic             break_q, break_d;

   logic [1:0]       byte_cnt_q, byte_cnt_d;
   logic [31:0]      word_q, word_d;
   logic [AW-1:0]    waddr_q, waddr_d;
   logic             done_q, done_d;
   logic             mem_we_d;
   logic [31:0]      mem_wdata_d;
   logic [31:0]      mem_q [IMEM_DEPTH];

   logic half_done_c, bit_done_c, zero_data_c;

   assign half_done_c = (cnt_q == CNT_W'(HALF_LAST));
   assign bit_done_c  = (cnt_q == CNT_W'(BIT_LAST));
   assign zero_data_c = (shift_q == 8'h00);

   // Two-flop synchronisers; the line idles high so its chain resets to 1.
   always_ff @(posedge clk) begin
      if (rst) begin
         rxd_meta_q  <= 1'b1;
         rxd_sync_q  <= 1'b1;
         gpio_meta_q <= '0;
         gpio_sync_q <= '0;
      end else begin
         rxd_meta_q  <= bus.uart_rxd;
         rxd_sync_q  <= rxd_meta_q;
         gpio_meta_q <= bus.input_gpio_pins;
         gpio_sync_q <= gpio_meta_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (!rxd_sync_q) state_d = S_START;
         S_START: if (half_done_c) state_d = rxd_sync_q ? S_IDLE : S_DATA;
         S_DATA:  if (bit_done_c && (bit_idx_q == 3'd7)) state_d = S_STOP;
         S_STOP: begin
            if (bit_done_c) begin
               state_d = S_IDLE;
`ifdef UART_BREAK_DETECT_EN
               if (!rxd_sync_q && zero_data_c) state_d = S_BRK_WAIT;
`endif
            end
         end
         S_BRK_WAIT: if (rxd_sync_q) state_d = S_IDLE;
         default:    state_d = S_IDLE;
      endcase
      // Dropping the enable aborts any frame in progress.
      if (!bus.uart_rx_en) state_d = S_IDLE;
   end

   always_comb begin
      cnt_d     = cnt_q + CNT_W'(1);
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      rx_data_d = rx_data_q;
      valid_d   = 1'b0;
      break_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            cnt_d     = '0;
            bit_idx_d = 3'd0;
         end
         S_START: if (half_done_c) cnt_d = '0;
         S_DATA: begin
            if (bit_done_c) begin
               cnt_d     = '0;
               shift_d   = {rxd_sync_q, shift_q[7:1]};
               bit_idx_d = bit_idx_q + 3'd1;
            end
         end
         S_STOP: begin
            if (bit_done_c) begin
               cnt_d = '0;
               if (rxd_sync_q) begin
                  valid_d   = 1'b1;
                  rx_data_d = shift_q;
               end
`ifdef UART_BREAK_DETECT_EN
               else if (zero_data_c) begin
                  break_d = 1'b1;
               end
`endif
            end
         end
         default: cnt_d = '0;
      endcase
      if (!bus.uart_rx_en) begin
         cnt_d   = '0;
         valid_d = 1'b0;
         break_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q     <= '0;
         bit_idx_q <= 3'd0;
         shift_q   <= 8'h00;
         rx_data_q <= 8'h00;
         valid_q   <= 1'b0;
         break_q   <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         bit_idx_q <= bit_idx_d;
         shift_q   <= shift_d;
         rx_data_q <= rx_data_d;
         valid_q   <= valid_d;
         break_q   <= break_d;
      end
   end

   // Word assembly: the fourth byte is combined with the three buffered ones.
   always_comb begin
      byte_cnt_d  = byte_cnt_q;
      word_d      = word_q;
      waddr_d     = waddr_q;
      done_d      = done_q;
      mem_we_d    = 1'b0;
      mem_wdata_d = {rx_data_q, word_q[23:0]};
      if (valid_q && !done_q) begin
         if (byte_cnt_q == 2'd3) begin
            byte_cnt_d = 2'd0;
            if (mem_wdata_d == 32'hFFFF_FFFF) begin
               done_d = 1'b1;
            end else begin
               mem_we_d = 1'b1;
               waddr_d  = waddr_q + AW'(1);
               if (waddr_q == AW'(LAST_ADDR)) done_d = 1'b1;
            end
         end else begin
            word_d[{byte_cnt_q, 3'b000} +: 8] = rx_data_q;
            byte_cnt_d = byte_cnt_q + 2'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         byte_cnt_q <= 2'd0;
         word_q     <= 32'h0;
         waddr_q    <= '0;
         done_q     <= 1'b0;
      end else begin
         byte_cnt_q <= byte_cnt_d;
         word_q     <= word_d;
         waddr_q    <= waddr_d;
         done_q     <= done_d;
      end
   end

   // Memory contents survive reset; writes are only blocked while it is held.
   always_ff @(posedge clk) begin
      if (mem_we_d && !rst) mem_q[waddr_q] <= mem_wdata_d;
   end

   assign gpio_out_d = done_q ? GPIO_OUT_W'(gpio_sync_q) : '0;

   always_ff @(posedge clk) begin
      if (rst) gpio_out_q <= '0;
      else     gpio_out_q <= gpio_out_d;
   end

   assign bus.uart_rx_valid    = valid_q;
   assign bus.uart_rx_data     = rx_data_q;
   assign bus.write_done       = done_q;
   assign bus.output_gpio_pins = gpio_out_q;
   assign bus.imem_rdata       = mem_q[bus.imem_raddr];
`ifdef UART_BREAK_DETECT_EN
   assign bus.uart_rx_break    = break_q;
`else
   assign bus.uart_rx_break    = 1'b0;
`endif

endmodule

// File: tb/tb_uart_gpio_loader.sv
// Directed bench for uart_gpio_loader at 16 clocks per bit with a 4-word memory.
module tb_uart_gpio_loader;

   localparam int unsigned CPB = 16;

   logic clk = 1'b0;
   logic rst;
   int   n_checks = 0;
   int   n_pass   = 0;
   int   valid_cnt = 0;
   int   break_cnt = 0;
   int   both_cnt  = 0;
   int   v0;
   int   b0;

   always #5 clk = ~clk;

   uart_gpio_loader_if #(.GPIO_IN_W(1), .GPIO_OUT_W(1), .AW(2)) bus ();

   uart_gpio_loader #(
      .CLK_HZ(1600), .BIT_RATE(100), .IMEM_DEPTH(4), .GPIO_IN_W(1), .GPIO_OUT_W(1)
   ) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always @(posedge clk) begin
      if (bus.uart_rx_valid === 1'b1) valid_cnt <= valid_cnt + 1;
      if (bus.uart_rx_break === 1'b1) break_cnt <= break_cnt + 1;
      if ((bus.uart_rx_valid === 1'b1) && (bus.uart_rx_break === 1'b1)) both_cnt <= both_cnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic drive_rx(input logic v, input int n);
      bus.uart_rxd = v;
      repeat (n) @(negedge clk);
   endtask

   // Full frame; a bad stop bit is held low for only 3/4 of a bit time.
   task automatic send_frame(input logic [7:0] d, input logic stop_ok);
      drive_rx(1'b0, CPB);
      for (int i = 0; i < 8; i++) drive_rx(d[i], CPB);
      if (stop_ok) drive_rx(1'b1, CPB);
      else         drive_rx(1'b0, 12);
      drive_rx(1'b1, 16);
   endtask

   task automatic send_byte_chk(input logic [7:0] b);
      int v;
      v = valid_cnt;
      send_frame(b, 1'b1);
      check($sformatf("valid_pulse_%h", b), 32'(valid_cnt), 32'(v + 1));
      check($sformatf("rx_data_%h", b), 32'(bus.uart_rx_data), 32'(b));
   endtask

   task automatic send_word(input logic [31:0] w);
      for (int k = 0; k < 4; k++) send_byte_chk(w[8*k +: 8]);
   endtask

   task automatic check_mem(input logic [1:0] a, input logic [31:0] exp);
      bus.imem_raddr = a;
      #1;
      check($sformatf("mem_%0d", a), bus.imem_rdata, exp);
   endtask

   // Pin change at a falling edge reaches the output on the third rising edge.
   task automatic gpio_step(input logic v);
      bus.input_gpio_pins = v;
      repeat (2) @(negedge clk);
      check("gpio_before_latency", 32'(bus.output_gpio_pins), 32'(!v));
      @(negedge clk);
      check("gpio_after_latency", 32'(bus.output_gpio_pins), 32'(v));
      repeat (197) @(negedge clk);
   endtask

   initial begin
      rst = 1'b1;
      bus.uart_rxd = 1'b1;
      bus.uart_rx_en = 1'b0;
      bus.input_gpio_pins = 1'b0;
      bus.imem_raddr = 2'd0;
      repeat (200) @(negedge clk);
      check("rst_valid", 32'(bus.uart_rx_valid), 32'd0);
      check("rst_break", 32'(bus.uart_rx_break), 32'd0);
      check("rst_data", 32'(bus.uart_rx_data), 32'd0);
      check("rst_done", 32'(bus.write_done), 32'd0);
      check("rst_gpio", 32'(bus.output_gpio_pins), 32'd0);
      check("rst_no_pulse", 32'(valid_cnt), 32'd0);
      rst = 1'b0;
      bus.uart_rx_en = 1'b1;
      repeat (4) @(negedge clk);

      send_byte_chk(8'hA5);
      repeat (50) @(negedge clk);
      check("a5_held", 32'(bus.uart_rx_data), 32'h0000_00A5);
      check("a5_single_pulse", 32'(valid_cnt), 32'd1);

      // Drop the partial word, then fill all four slots.
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      send_word(32'h1111_1111);
      send_word(32'h2222_2222);
      send_word(32'h3333_3333);
      check("not_full_yet", 32'(bus.write_done), 32'd0);
      send_word(32'h4444_4444);
      check("full_done", 32'(bus.write_done), 32'd1);
      check_mem(2'd0, 32'h1111_1111);
      check_mem(2'd3, 32'h4444_4444);

      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check("rst2_done", 32'(bus.write_done), 32'd0);
      check_mem(2'd3, 32'h4444_4444);

      for (int i = 0; i < 4; i++) begin
         bus.input_gpio_pins = ~bus.input_gpio_pins;
         repeat (200) @(negedge clk);
         check("gpio_gated", 32'(bus.output_gpio_pins), 32'd0);
      end
      bus.input_gpio_pins = 1'b0;
      repeat (4) @(negedge clk);

      send_word(32'hFE01_0113);
      send_word(32'h0081_2E23);
      check_mem(2'd0, 32'hFE01_0113);
      check_mem(2'd1, 32'h0081_2E23);
      check("two_words_done", 32'(bus.write_done), 32'd0);

      // Enable dropped after four data bits: no pulse.
      v0 = valid_cnt;
      drive_rx(1'b0, CPB);
      for (int i = 0; i < 4; i++) drive_rx(1'b1, CPB);
      bus.uart_rx_en = 1'b0;
      for (int i = 0; i < 4; i++) drive_rx(1'b0, CPB);
      drive_rx(1'b1, 2 * CPB);
      bus.uart_rx_en = 1'b1;
      repeat (4) @(negedge clk);
      check("abort_no_pulse", 32'(valid_cnt), 32'(v0));

      v0 = valid_cnt;
      b0 = break_cnt;
      send_frame(8'h5A, 1'b0);
      check("frame_err_no_valid", 32'(valid_cnt), 32'(v0));
      check("frame_err_no_break", 32'(break_cnt), 32'(b0));
      check("frame_err_data_kept", 32'(bus.uart_rx_data), 32'h0000_0000);

      send_word(32'hFFFF_FFFF);
      check("term_done", 32'(bus.write_done), 32'd1);
      check_mem(2'd2, 32'h3333_3333);
      send_word(32'hFFFF_FFFF);
      send_word(32'h1234_5678);
      check("post_done_sticky", 32'(bus.write_done), 32'd1);
      check_mem(2'd0, 32'hFE01_0113);
      check_mem(2'd1, 32'h0081_2E23);
      check_mem(2'd2, 32'h3333_3333);
      check_mem(2'd3, 32'h4444_4444);

      gpio_step(1'b1);
      gpio_step(1'b0);
      gpio_step(1'b1);
      gpio_step(1'b0);

`ifdef UART_BREAK_DETECT_EN
      v0 = valid_cnt;
      b0 = break_cnt;
      drive_rx(1'b0, 12 * CPB);
      drive_rx(1'b1, 4 * CPB);
      check("break_pulse", 32'(break_cnt), 32'(b0 + 1));
      check("break_no_valid", 32'(valid_cnt), 32'(v0));
      send_byte_chk(8'h96);
`else
      check("break_tied_low", 32'(break_cnt), 32'd0);
`endif

      bus.uart_rx_en = 1'b0;
      v0 = valid_cnt;
      b0 = break_cnt;
      send_frame(8'h3C, 1'b1);
      check("disabled_no_valid", 32'(valid_cnt), 32'(v0));
      check("disabled_no_break", 32'(break_cnt), 32'(b0));
      check("never_both", 32'(both_cnt), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
